// File: rtl/mul_pkg.sv
// Shared constants for the sequential 64x64 multiplier: FSM encoding and timing.
package mul_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int unsigned ITER_LAST = 63;
  localparam int unsigned MUL_LAT   = 65;

endpackage

// File: rtl/adder64.sv
// Plain 64-bit ripple/carry adder shared with the datapath; used here for accumulation.
module adder64 (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {64'b0, cin};

endmodule

// File: rtl/mul64_seq.sv
// Iterative shift-and-add 64x64 multiplier producing a 128-bit signed/unsigned product.
// Operands are reduced to magnitudes on accept; the sign is restored in a single fix-up cycle.
module mul64_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo,
  output logic             overflow
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic             sgn_q, sgn_d;
  logic [63:0]      ma_q, ma_d;
  logic [63:0]      acc_hi_q, acc_hi_d;
  logic [63:0]      acc_lo_q, acc_lo_d;
  logic [63:0]      prod_hi_q, prod_hi_d;
  logic [63:0]      prod_lo_q, prod_lo_d;
  logic             ovf_q, ovf_d;

  logic [63:0]  add_sum;
  logic         add_cout;
  logic         step_c;
  logic [63:0]  step_s;
  logic [63:0]  a_mag, b_mag;
  logic [127:0] res_full;

  adder64 u_adder (
    .a    (acc_hi_q),
    .b    (ma_q),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign prod_hi   = prod_hi_q;
  assign prod_lo   = prod_lo_q;
  assign overflow  = ovf_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    sgn_d     = sgn_q;
    ma_d      = ma_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    prod_hi_d = prod_hi_q;
    prod_lo_d = prod_lo_q;
    ovf_d     = ovf_q;

    a_mag    = (is_signed && a[63]) ? (~a + 64'd1) : a;
    b_mag    = (is_signed && b[63]) ? (~b + 64'd1) : b;
    step_c   = acc_lo_q[0] ? add_cout : 1'b0;
    step_s   = acc_lo_q[0] ? add_sum  : acc_hi_q;
    res_full = neg_q ? (~{acc_hi_q, acc_lo_q} + 128'd1) : {acc_hi_q, acc_lo_q};

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          neg_d    = is_signed & (a[63] ^ b[63]);
          sgn_d    = is_signed;
          ma_d     = a_mag;
          acc_hi_d = 64'd0;
          acc_lo_d = b_mag;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        // 129-bit {carry, sum, acc_lo} shifted right by one
        acc_hi_d = {step_c, step_s[63:1]};
        acc_lo_d = {step_s[0], acc_lo_q[63:1]};
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ITER_LAST)) state_d = S_FIX;
      end
      S_FIX: begin
        prod_hi_d = res_full[127:64];
        prod_lo_d = res_full[63:0];
        ovf_d     = sgn_q ? (res_full[127:64] != {64{res_full[63]}})
                          : (res_full[127:64] != 64'd0);
        state_d   = S_DONE;
      end
      default: begin
        if (out_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      sgn_q     <= 1'b0;
      ma_q      <= 64'd0;
      acc_hi_q  <= 64'd0;
      acc_lo_q  <= 64'd0;
      prod_hi_q <= 64'd0;
      prod_lo_q <= 64'd0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      sgn_q     <= sgn_d;
      ma_q      <= ma_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      prod_hi_q <= prod_hi_d;
      prod_lo_q <= prod_lo_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mul64_seq.sv
// Directed self-checking bench for mul64_seq: products, latency, handshake and reset.
module tb_mul64_seq;
  import mul_pkg::*;

  localparam int TIMEOUT = 300;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        is_signed;
  logic [63:0] a;
  logic [63:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] prod_hi;
  logic [63:0] prod_lo;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  mul64_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod_hi   (prod_hi),
    .prod_lo   (prod_lo),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Present operands for one edge from a negedge, starting in IDLE.
  task automatic start_mul(input logic sgn, input logic [63:0] av, input logic [63:0] bv);
    is_signed = sgn;
    a         = av;
    b         = bv;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  // Counts edges from the accept edge until out_valid, bounded by TIMEOUT.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < TIMEOUT) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    is_signed = 1'b0;
    a         = 64'd0;
    b         = 64'd0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid);
    end
    checks++;
    if ({prod_hi, prod_lo, overflow} !== 129'd0) begin
      failures++; $display("[TB] FAIL reset_outputs got=%h_%h_%b want=0", prod_hi, prod_lo, overflow);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unsigned_small();
    int lat;
    out_ready = 1'b1;
    start_mul(1'b0, 64'd3, 64'd5);
    wait_done(lat);
    checks++;
    if (lat != MUL_LAT) begin
      failures++; $display("[TB] FAIL u3x5_latency got=%0d want=%0d", lat, MUL_LAT);
    end
    checks++;
    if (prod_hi !== 64'd0 || prod_lo !== 64'd15 || overflow !== 1'b0) begin
      failures++; $display("[TB] FAIL u3x5_result got=%h_%h_%b want=0_f_0", prod_hi, prod_lo, overflow);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || prod_lo !== 64'd15) begin
      failures++; $display("[TB] FAIL u3x5_after_consume got=rdy%b vld%b lo%h want=rdy1 vld0 lo f",
                           in_ready, out_valid, prod_lo);
    end
  endtask

  task automatic test_unsigned_max();
    int lat;
    start_mul(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_done(lat);
    checks++;
    if (lat != MUL_LAT || prod_hi !== 64'hFFFF_FFFF_FFFF_FFFE || prod_lo !== 64'd1 || overflow !== 1'b1) begin
      failures++; $display("[TB] FAIL umax_sq got=lat%0d %h_%h_%b want=lat65 fffffffffffffffe_1_1",
                           lat, prod_hi, prod_lo, overflow);
    end
    @(negedge clk);
  endtask

  task automatic test_signed_neg();
    int lat;
    start_mul(1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd6);
    wait_done(lat);
    checks++;
    if (lat != MUL_LAT || prod_hi !== 64'hFFFF_FFFF_FFFF_FFFF || prod_lo !== 64'hFFFF_FFFF_FFFF_FFD6 || overflow !== 1'b0) begin
      failures++; $display("[TB] FAIL s_m7x6 got=lat%0d %h_%h_%b want=lat65 ffffffffffffffff_ffffffffffffffd6_0",
                           lat, prod_hi, prod_lo, overflow);
    end
    @(negedge clk);
  endtask

  task automatic test_signed_min();
    int lat;
    start_mul(1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    wait_done(lat);
    checks++;
    if (lat != MUL_LAT || prod_hi !== 64'h4000_0000_0000_0000 || prod_lo !== 64'd0 || overflow !== 1'b1) begin
      failures++; $display("[TB] FAIL s_min_sq got=lat%0d %h_%h_%b want=lat65 4000000000000000_0_1",
                           lat, prod_hi, prod_lo, overflow);
    end
    @(negedge clk);
  endtask

  task automatic test_handshake_stall();
    int lat;
    out_ready = 1'b0;
    start_mul(1'b0, 64'd10, 64'd10);
    wait_done(lat);
    checks++;
    if (lat != MUL_LAT || prod_lo !== 64'd100) begin
      failures++; $display("[TB] FAIL stall_result got=lat%0d lo%h want=lat65 lo64", lat, prod_lo);
    end
    // Operands offered while DONE must be ignored.
    is_signed = 1'b0;
    a         = 64'd99;
    b         = 64'd99;
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || prod_hi !== 64'd0 || prod_lo !== 64'd100 || overflow !== 1'b0) begin
        failures++; $display("[TB] FAIL stall_hold[%0d] got=vld%b rdy%b %h_%h_%b want=vld1 rdy0 0_64_0",
                             i, out_valid, in_ready, prod_hi, prod_lo, overflow);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    a         = 64'd4;
    b         = 64'd4;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || prod_lo !== 64'd100) begin
      failures++; $display("[TB] FAIL b2b_consume got=vld%b rdy%b lo%h want=vld0 rdy1 lo64",
                           out_valid, in_ready, prod_lo);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("[TB] FAIL b2b_accept got=rdy%b want=rdy0", in_ready);
    end
    wait_done(lat);
    checks++;
    if (lat != MUL_LAT || prod_hi !== 64'd0 || prod_lo !== 64'd16) begin
      failures++; $display("[TB] FAIL b2b_result got=lat%0d %h_%h want=lat65 0_10", lat, prod_hi, prod_lo);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int lat;
    start_mul(1'b0, 64'd7, 64'd9);
    repeat (29) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL midrst_state got=rdy%b vld%b want=rdy1 vld0", in_ready, out_valid);
    end
    checks++;
    if ({prod_hi, prod_lo, overflow} !== 129'd0) begin
      failures++; $display("[TB] FAIL midrst_outputs got=%h_%h_%b want=0", prod_hi, prod_lo, overflow);
    end
    rst_n = 1'b1;
    start_mul(1'b0, 64'd2, 64'd2);
    wait_done(lat);
    checks++;
    if (lat != MUL_LAT || prod_hi !== 64'd0 || prod_lo !== 64'd4 || overflow !== 1'b0) begin
      failures++; $display("[TB] FAIL midrst_2x2 got=lat%0d %h_%h_%b want=lat65 0_4_0",
                           lat, prod_hi, prod_lo, overflow);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_unsigned_small();
    test_unsigned_max();
    test_signed_neg();
    test_signed_min();
    test_handshake_stall();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
